// File: rtl/fractal_dispatch.sv
// Round-robin pixel dispatcher: issues coordinates to CORE_COUNT cores, collects results in issue
// order and emits a raster pixel stream with sof/eol/eof. Optional colour map: FRACTAL_DISPATCH_COLOUR_MAP_EN.
module fractal_dispatch #(
  parameter int CORE_COUNT     = 9,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_ITER_WIDTH = 16,
  parameter int X_SIZE         = 640,
  parameter int Y_SIZE         = 480
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               frame_start_i,
  input  logic [DATA_WIDTH-1:0]              x_start_i,
  input  logic [DATA_WIDTH-1:0]              y_start_i,
  input  logic [DATA_WIDTH-1:0]              step_i,
  input  logic [MAX_ITER_WIDTH-1:0]          max_iter_i,
  output logic [CORE_COUNT-1:0]              core_start_o,
  output logic [CORE_COUNT*DATA_WIDTH-1:0]   core_x0_o,
  output logic [CORE_COUNT*DATA_WIDTH-1:0]   core_y0_o,
  input  logic [CORE_COUNT-1:0]              core_done_i,
  input  logic [CORE_COUNT*MAX_ITER_WIDTH-1:0] core_iter_i,
  output logic [23:0]                        pix_data_o,
  output logic                               pix_valid_o,
  input  logic                               pix_ready_i,
  output logic                               pix_sof_o,
  output logic                               pix_eol_o,
  output logic                               pix_eof_o,
  output logic                               busy_o
);

  localparam int PW    = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;
  localparam int XW    = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
  localparam int YW    = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
  localparam int TOTAL = X_SIZE * Y_SIZE;
  localparam int CW    = $clog2(TOTAL + 1);

  localparam logic [PW-1:0] P_LAST  = PW'(CORE_COUNT - 1);
  localparam logic [XW-1:0] X_LAST  = XW'(X_SIZE - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(Y_SIZE - 1);
  localparam logic [CW-1:0] C_TOTAL = CW'(TOTAL);
  localparam logic [CW-1:0] C_LAST  = CW'(TOTAL - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DRAIN} state_t;

  state_t                          r_state;
  logic [DATA_WIDTH-1:0]           r_xstart;
  logic [DATA_WIDTH-1:0]           r_step;
  logic [DATA_WIDTH-1:0]           r_xn;
  logic [DATA_WIDTH-1:0]           r_yn;
  logic [XW-1:0]                   r_ix;
  logic [CW-1:0]                   r_issued;
  logic [CW-1:0]                   r_collected;
  logic [PW-1:0]                   r_issue_ptr;
  logic [PW-1:0]                   r_col_ptr;
  logic [XW-1:0]                   r_cx;
  logic [YW-1:0]                   r_cy;
  logic [CORE_COUNT-1:0]           r_core_start;
  logic [CORE_COUNT*DATA_WIDTH-1:0] r_core_x0;
  logic [CORE_COUNT*DATA_WIDTH-1:0] r_core_y0;
  logic [23:0]                     r_pix_data;
  logic                            r_pix_valid;
  logic                            r_sof;
  logic                            r_eol;
  logic                            r_eof;
  logic                            r_busy;

  logic [MAX_ITER_WIDTH-1:0]       w_iter;
  logic [23:0]                     w_pix;
  logic                            w_done;
  logic                            w_out_free;
  logic                            w_take;
  logic                            w_issue;

  // A core whose start pulse is still on the wire may show a stale done from its previous pixel.
  assign w_done     = core_done_i[r_col_ptr] & ~r_core_start[r_col_ptr];
  assign w_iter     = core_iter_i[r_col_ptr*MAX_ITER_WIDTH +: MAX_ITER_WIDTH];
  assign w_out_free = ~r_pix_valid | pix_ready_i;
  assign w_take     = (r_state == S_RUN) & w_done & w_out_free;
  assign w_issue    = (r_state == S_FILL) | (w_take & (r_issued != C_TOTAL));

`ifdef FRACTAL_DISPATCH_COLOUR_MAP_EN
  logic [MAX_ITER_WIDTH-1:0] r_max_iter;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_max_iter <= '0;
    end else if ((r_state == S_IDLE) && frame_start_i) begin
      r_max_iter <= max_iter_i;
    end
  end

  assign w_pix = (w_iter == r_max_iter) ? 24'h000000 :
                 {w_iter[7:0], w_iter[6:0], 1'b0, 8'hFF - w_iter[7:0]};
`else
  logic w_unused;
  assign w_unused = ^{max_iter_i, w_iter};
  assign w_pix    = {3{w_iter[7:0]}};
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_xstart     <= '0;
      r_step       <= '0;
      r_xn         <= '0;
      r_yn         <= '0;
      r_ix         <= '0;
      r_issued     <= '0;
      r_collected  <= '0;
      r_issue_ptr  <= '0;
      r_col_ptr    <= '0;
      r_cx         <= '0;
      r_cy         <= '0;
      r_core_start <= '0;
      r_core_x0    <= '0;
      r_core_y0    <= '0;
      r_pix_data   <= '0;
      r_pix_valid  <= 1'b0;
      r_sof        <= 1'b0;
      r_eol        <= 1'b0;
      r_eof        <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_core_start <= '0;

      if (w_issue) begin
        r_core_start[r_issue_ptr]                      <= 1'b1;
        r_core_x0[r_issue_ptr*DATA_WIDTH +: DATA_WIDTH] <= r_xn;
        r_core_y0[r_issue_ptr*DATA_WIDTH +: DATA_WIDTH] <= r_yn;
        r_issue_ptr <= (r_issue_ptr == P_LAST) ? '0 : r_issue_ptr + 1'b1;
        r_issued    <= r_issued + 1'b1;
        if (r_ix == X_LAST) begin
          r_ix <= '0;
          r_xn <= r_xstart;
          r_yn <= r_yn + r_step;
        end else begin
          r_ix <= r_ix + 1'b1;
          r_xn <= r_xn + r_step;
        end
      end

      if (w_take) begin
        r_pix_valid <= 1'b1;
        r_pix_data  <= w_pix;
        r_sof       <= (r_cx == '0) && (r_cy == '0);
        r_eol       <= (r_cx == X_LAST);
        r_eof       <= (r_cx == X_LAST) && (r_cy == Y_LAST);
        r_col_ptr   <= (r_col_ptr == P_LAST) ? '0 : r_col_ptr + 1'b1;
        r_collected <= r_collected + 1'b1;
        if (r_cx == X_LAST) begin
          r_cx <= '0;
          r_cy <= r_cy + 1'b1;
        end else begin
          r_cx <= r_cx + 1'b1;
        end
      end else if (pix_ready_i) begin
        r_pix_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (frame_start_i) begin
            r_xstart    <= x_start_i;
            r_step      <= step_i;
            r_xn        <= x_start_i;
            r_yn        <= y_start_i;
            r_ix        <= '0;
            r_issued    <= '0;
            r_collected <= '0;
            r_issue_ptr <= '0;
            r_col_ptr   <= '0;
            r_cx        <= '0;
            r_cy        <= '0;
            r_busy      <= 1'b1;
            r_state     <= S_FILL;
          end
        end
        S_FILL: begin
          if ((r_issue_ptr == P_LAST) || (r_issued == C_LAST)) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_take && (r_collected == C_LAST)) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // The final pixel sits in the output register until accepted.
          if (pix_ready_i) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign core_start_o = r_core_start;
  assign core_x0_o    = r_core_x0;
  assign core_y0_o    = r_core_y0;
  assign pix_data_o   = r_pix_data;
  assign pix_valid_o  = r_pix_valid;
  assign pix_sof_o    = r_sof;
  assign pix_eol_o    = r_eol;
  assign pix_eof_o    = r_eof;
  assign busy_o       = r_busy;

endmodule
